// File: rtl/btb_multi_lane.sv
// Multi-lane branch target buffer: one bank per fetch lane, tagged entries with
// 2-bit direction counters, registered response, and a multi-cycle invalidate sweep.
module btb_multi_lane #(
  parameter int FETCH_WIDTH = 4,
  parameter int ENTRIES     = 16,
  parameter int TAG_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lookup_valid_i,
  input  logic [31:0]               lookup_vaddr_i,
  input  logic [FETCH_WIDTH-1:0]    lookup_enable_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      upd_valid_i,
  input  logic [31:0]               upd_vaddr_i,
  input  logic                      upd_taken_i,
  input  logic [31:0]               upd_dest_i,
  output logic                      resp_valid_o,
  output logic [FETCH_WIDTH-1:0]    pred_take_o,
  output logic [32*FETCH_WIDTH-1:0] pred_dest_o,
  output logic                      any_take_o,
  output logic [$clog2(FETCH_WIDTH)-1:0] first_take_idx_o,
  output logic [31:0]               valid_dest_o,
  output logic                      need_delay_slot_o,
  output logic                      busy_o
);
  localparam int LB = $clog2(FETCH_WIDTH);
  localparam int IB = $clog2(ENTRIES);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e state_q, state_d;
  logic [IB-1:0] cnt_q, cnt_d;

  logic [FETCH_WIDTH-1:0][ENTRIES-1:0]      valid_q;
  logic [FETCH_WIDTH-1:0][ENTRIES-1:0][1:0] ctr_q;
  logic [TAG_W-1:0] tag_q  [FETCH_WIDTH][ENTRIES];
  logic [31:2]      dest_q [FETCH_WIDTH][ENTRIES];

  // Lookup address decode: the group base is aligned, so every lane uses one index/tag.
  logic [31:0]      base;
  logic [IB-1:0]    lk_idx;
  logic [TAG_W-1:0] lk_tag;
  assign base   = {lookup_vaddr_i[31:LB+2], {(LB+2){1'b0}}};
  assign lk_idx = lookup_vaddr_i[LB+IB+1:LB+2];
  assign lk_tag = lookup_vaddr_i[LB+IB+TAG_W+1:LB+IB+2];

  logic [LB-1:0]    up_lane;
  logic [IB-1:0]    up_idx;
  logic [TAG_W-1:0] up_tag;
  assign up_lane = upd_vaddr_i[LB+1:2];
  assign up_idx  = upd_vaddr_i[LB+IB+1:LB+2];
  assign up_tag  = upd_vaddr_i[LB+IB+TAG_W+1:LB+IB+2];

  logic unused_bits;
  assign unused_bits = ^{upd_vaddr_i, upd_dest_i[1:0], lookup_vaddr_i[LB+1:0]};

  logic [FETCH_WIDTH-1:0]         take;
  logic [FETCH_WIDTH-1:0][31:0]   dest;
  logic [LB-1:0]                  first;
  logic                           any;
  logic [31:0]                    next_pc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    take  = '0;
    dest  = '0;
    first = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      take[i] = valid_q[i][lk_idx] && (tag_q[i][lk_idx] == lk_tag)
                && ctr_q[i][lk_idx][1] && lookup_enable_i[i];
      dest[i] = take[i] ? {dest_q[i][lk_idx], 2'b00} : base + 32'(4 * i + 8);
    end
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (take[i]) first = LB'(i);
    end
    any     = |take;
    next_pc = any ? dest[first] : base + 32'(4 * FETCH_WIDTH);
  end

  logic       upd_en, upd_hit;
  logic [1:0] ctr_new;

  always_comb begin
    upd_hit = valid_q[up_lane][up_idx] && (tag_q[up_lane][up_idx] == up_tag);
    upd_en  = upd_valid_i && (state_q == IDLE) && !flush_i;
    ctr_new = ctr_q[up_lane][up_idx];
    if (!upd_hit)                 ctr_new = 2'b10;
    else if (upd_taken_i)         ctr_new = (ctr_new == 2'b11) ? 2'b11 : ctr_new + 2'b01;
    else if (ctr_new != 2'b00)    ctr_new = ctr_new - 2'b01;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (flush_i) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == IB'(ENTRIES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking writes, which also gives lookups
  // read-before-write semantics against a same-edge update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == FLUSH) begin
        for (int l = 0; l < FETCH_WIDTH; l++) valid_q[l][cnt_q] <= 1'b0;
      end else if (upd_en && (upd_hit || upd_taken_i)) begin
        valid_q[up_lane][up_idx] <= 1'b1;
        ctr_q[up_lane][up_idx]   <= ctr_new;
      end
    end
  end

  // NOTE: tag/dest arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken_i) begin
      tag_q[up_lane][up_idx]  <= up_tag;
      dest_q[up_lane][up_idx] <= upd_dest_i[31:2];
    end
  end

  logic                         resp_valid_q, any_q, need_ds_q;
  logic [FETCH_WIDTH-1:0]       take_q;
  logic [FETCH_WIDTH-1:0][31:0] pred_dest_q;
  logic [LB-1:0]                first_q;
  logic [31:0]                  next_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      take_q       <= '0;
      pred_dest_q  <= '0;
      any_q        <= 1'b0;
      first_q      <= '0;
      next_pc_q    <= '0;
      need_ds_q    <= 1'b0;
    end else if (!stall_i) begin
      resp_valid_q <= lookup_valid_i && (state_q == IDLE);
      take_q       <= take;
      pred_dest_q  <= dest;
      any_q        <= any;
      first_q      <= first;
      next_pc_q    <= next_pc;
      need_ds_q    <= any && (first == LB'(FETCH_WIDTH - 1));
    end
  end

  assign resp_valid_o      = resp_valid_q;
  assign pred_take_o       = take_q;
  assign pred_dest_o       = pred_dest_q;
  assign any_take_o        = any_q;
  assign first_take_idx_o  = first_q;
  assign valid_dest_o      = next_pc_q;
  assign need_delay_slot_o = need_ds_q;
  assign busy_o            = (state_q == FLUSH);
endmodule

// File: tb/tb_btb_multi_lane.sv
// Directed self-checking bench for btb_multi_lane (FETCH_WIDTH=4, ENTRIES=16, TAG_W=8).
module tb_btb_multi_lane;
  logic         clk = 1'b0;
  logic         rst;
  logic         lookup_valid_i;
  logic [31:0]  lookup_vaddr_i;
  logic [3:0]   lookup_enable_i;
  logic         stall_i, flush_i, upd_valid_i, upd_taken_i;
  logic [31:0]  upd_vaddr_i, upd_dest_i;
  logic         resp_valid_o, any_take_o, need_delay_slot_o, busy_o;
  logic [3:0]   pred_take_o;
  logic [127:0] pred_dest_o;
  logic [1:0]   first_take_idx_o;
  logic [31:0]  valid_dest_o;

  int checks = 0;
  int errors = 0;

  btb_multi_lane #(.FETCH_WIDTH(4), .ENTRIES(16), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid_i(lookup_valid_i), .lookup_vaddr_i(lookup_vaddr_i),
    .lookup_enable_i(lookup_enable_i), .stall_i(stall_i), .flush_i(flush_i),
    .upd_valid_i(upd_valid_i), .upd_vaddr_i(upd_vaddr_i),
    .upd_taken_i(upd_taken_i), .upd_dest_i(upd_dest_i),
    .resp_valid_o(resp_valid_o), .pred_take_o(pred_take_o),
    .pred_dest_o(pred_dest_o), .any_take_o(any_take_o),
    .first_take_idx_o(first_take_idx_o), .valid_dest_o(valid_dest_o),
    .need_delay_slot_o(need_delay_slot_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive one lookup at a negedge; returns at the next negedge with outputs settled.
  task automatic do_lookup(input logic [31:0] a, input logic [3:0] en);
    lookup_valid_i  = 1'b1;
    lookup_vaddr_i  = a;
    lookup_enable_i = en;
    @(negedge clk);
    lookup_valid_i  = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] a, input logic tk, input logic [31:0] d);
    upd_valid_i = 1'b1;
    upd_vaddr_i = a;
    upd_taken_i = tk;
    upd_dest_i  = d;
    @(negedge clk);
    upd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    lookup_valid_i = 0; lookup_vaddr_i = 0; lookup_enable_i = 0;
    stall_i = 0; flush_i = 0; upd_valid_i = 0; upd_vaddr_i = 0;
    upd_taken_i = 0; upd_dest_i = 0;
    #2;
    checks++;
    if ({resp_valid_o, pred_take_o, any_take_o, busy_o, need_delay_slot_o} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b expected 0", {resp_valid_o, pred_take_o, any_take_o, busy_o});
    end
    checks++;
    if (pred_dest_o !== 128'h0 || valid_dest_o !== 32'h0) begin
      errors++; $display("FAIL reset_dest: got %h/%h expected 0", pred_dest_o, valid_dest_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_lookup();
    do_lookup(32'h1000_0040, 4'b1111);
    checks++;
    if (resp_valid_o !== 1'b1 || pred_take_o !== 4'b0000 || any_take_o !== 1'b0) begin
      errors++; $display("FAIL miss_flags: got v=%b t=%b a=%b expected v=1 t=0000 a=0", resp_valid_o, pred_take_o, any_take_o);
    end
    checks++;
    if (pred_dest_o !== {32'h1000_0054, 32'h1000_0050, 32'h1000_004C, 32'h1000_0048}) begin
      errors++; $display("FAIL miss_pred_dest: got %h expected 10000054_10000050_1000004c_10000048", pred_dest_o);
    end
    checks++;
    if (valid_dest_o !== 32'h1000_0050) begin
      errors++; $display("FAIL miss_valid_dest: got %h expected 10000050", valid_dest_o);
    end
  endtask

  task automatic test_alloc();
    do_update(32'h1000_0044, 1'b1, 32'h2000_0000);
    do_lookup(32'h1000_0047, 4'b1111);   // low bits ignored
    checks++;
    if (pred_take_o !== 4'b0010 || first_take_idx_o !== 2'd1 || need_delay_slot_o !== 1'b0) begin
      errors++; $display("FAIL alloc_take: got t=%b f=%0d ds=%b expected t=0010 f=1 ds=0", pred_take_o, first_take_idx_o, need_delay_slot_o);
    end
    checks++;
    if (valid_dest_o !== 32'h2000_0000 || pred_dest_o[63:32] !== 32'h2000_0000) begin
      errors++; $display("FAIL alloc_dest: got %h/%h expected 20000000", valid_dest_o, pred_dest_o[63:32]);
    end
    do_lookup(32'h1000_1040, 4'b1111);
    checks++;
    if (pred_take_o !== 4'b0000 || valid_dest_o !== 32'h1000_1050) begin
      errors++; $display("FAIL alloc_tag_miss: got t=%b d=%h expected t=0000 d=10001050", pred_take_o, valid_dest_o);
    end
  endtask

  task automatic test_saturation();
    repeat (3) do_update(32'h1000_004C, 1'b1, 32'h3000_0000);
    do_lookup(32'h1000_0040, 4'b1000);
    checks++;
    if (pred_take_o !== 4'b1000 || first_take_idx_o !== 2'd3 || need_delay_slot_o !== 1'b1 || valid_dest_o !== 32'h3000_0000) begin
      errors++; $display("FAIL sat_lane3: got t=%b f=%0d ds=%b d=%h expected t=1000 f=3 ds=1 d=30000000", pred_take_o, first_take_idx_o, need_delay_slot_o, valid_dest_o);
    end
    do_update(32'h1000_004C, 1'b0, 32'h0);
    do_lookup(32'h1000_0040, 4'b1000);
    checks++;
    if (pred_take_o !== 4'b1000) begin
      errors++; $display("FAIL sat_ctr2: got %b expected 1000", pred_take_o);
    end
    do_update(32'h1000_004C, 1'b0, 32'h0);
    do_lookup(32'h1000_0040, 4'b1111);
    checks++;
    if (pred_take_o !== 4'b0010 || first_take_idx_o !== 2'd1 || need_delay_slot_o !== 1'b0) begin
      errors++; $display("FAIL sat_ctr1: got t=%b f=%0d ds=%b expected t=0010 f=1 ds=0", pred_take_o, first_take_idx_o, need_delay_slot_o);
    end
  endtask

  task automatic test_enable_mask();
    do_lookup(32'h1000_0040, 4'b1101);
    checks++;
    if (any_take_o !== 1'b0 || valid_dest_o !== 32'h1000_0050 || pred_dest_o[63:32] !== 32'h1000_004C) begin
      errors++; $display("FAIL mask: got a=%b d=%h l1=%h expected a=0 d=10000050 l1=1000004c", any_take_o, valid_dest_o, pred_dest_o[63:32]);
    end
    do_lookup(32'hFFFF_FFF0, 4'b1111);
    checks++;
    if (valid_dest_o !== 32'h0000_0000 || pred_dest_o[127:96] !== 32'h0000_0004) begin
      errors++; $display("FAIL wrap: got d=%h l3=%h expected d=00000000 l3=00000004", valid_dest_o, pred_dest_o[127:96]);
    end
  endtask

  task automatic test_back_to_back();
    // Same-edge lookup and allocate of one entry: lookup sees the old contents.
    lookup_valid_i = 1'b1; lookup_vaddr_i = 32'h1000_0200; lookup_enable_i = 4'b1111;
    upd_valid_i = 1'b1; upd_vaddr_i = 32'h1000_0200; upd_taken_i = 1'b1; upd_dest_i = 32'h5000_0000;
    @(negedge clk);
    upd_valid_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1 || pred_take_o !== 4'b0000) begin
      errors++; $display("FAIL rbw_old: got v=%b t=%b expected v=1 t=0000", resp_valid_o, pred_take_o);
    end
    lookup_vaddr_i = 32'h1000_0200;
    @(negedge clk);
    lookup_vaddr_i = 32'h1000_0040;
    checks++;
    if (pred_take_o !== 4'b0001 || valid_dest_o !== 32'h5000_0000) begin
      errors++; $display("FAIL rbw_new: got t=%b d=%h expected t=0001 d=50000000", pred_take_o, valid_dest_o);
    end
    @(negedge clk);
    lookup_valid_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1 || pred_take_o !== 4'b0010 || valid_dest_o !== 32'h2000_0000) begin
      errors++; $display("FAIL b2b_second: got v=%b t=%b d=%h expected v=1 t=0010 d=20000000", resp_valid_o, pred_take_o, valid_dest_o);
    end
  endtask

  task automatic test_flush();
    int n;
    do_update(32'h1000_0080, 1'b1, 32'h4000_0000);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    lookup_valid_i = 1'b1; lookup_vaddr_i = 32'h1000_0080; lookup_enable_i = 4'b1111;
    upd_valid_i = 1'b1; upd_vaddr_i = 32'h1000_0100; upd_taken_i = 1'b1; upd_dest_i = 32'h6000_0000;
    n = 0;
    while (busy_o && n < 64) begin
      n++;
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (resp_valid_o !== 1'b0) begin
          errors++; $display("FAIL flush_resp_valid: got %b expected 0", resp_valid_o);
        end
        lookup_valid_i = 1'b0; upd_valid_i = 1'b0;
      end
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL flush_busy_len: got %0d expected 16", n);
    end
    do_lookup(32'h1000_0040, 4'b1111);
    checks++;
    if (any_take_o !== 1'b0) begin
      errors++; $display("FAIL flush_clear_a: got %b expected 0", any_take_o);
    end
    do_lookup(32'h1000_0080, 4'b1111);
    checks++;
    if (any_take_o !== 1'b0) begin
      errors++; $display("FAIL flush_clear_b: got %b expected 0", any_take_o);
    end
    do_lookup(32'h1000_0100, 4'b1111);
    checks++;
    if (any_take_o !== 1'b0 || resp_valid_o !== 1'b1) begin
      errors++; $display("FAIL flush_upd_dropped: got a=%b v=%b expected a=0 v=1", any_take_o, resp_valid_o);
    end
  endtask

  task automatic test_flush_restart();
    int n;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL restart_mid_busy: got %b expected 1", busy_o);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n = 0;
    while (busy_o && n < 64) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL restart_busy_len: got %0d expected 16", n);
    end
  endtask

  task automatic test_stall();
    do_update(32'h1000_0044, 1'b1, 32'h2000_0000);
    lookup_valid_i = 1'b1; lookup_vaddr_i = 32'h1000_0040; lookup_enable_i = 4'b1111;
    @(negedge clk);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lookup_vaddr_i  = 32'h3000_0000 + 32'(k * 256);
      lookup_valid_i  = k[0];
      lookup_enable_i = 4'b0001;
      @(negedge clk);
      checks++;
      if (resp_valid_o !== 1'b1 || pred_take_o !== 4'b0010 || valid_dest_o !== 32'h2000_0000 || pred_dest_o[31:0] !== 32'h1000_0048) begin
        errors++; $display("FAIL stall_hold_%0d: got v=%b t=%b d=%h expected v=1 t=0010 d=20000000", k, resp_valid_o, pred_take_o, valid_dest_o);
      end
    end
    stall_i = 1'b0;
    lookup_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_release: got %b expected 0", resp_valid_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    lookup_valid_i = 1'b1; lookup_vaddr_i = 32'h1000_0040; lookup_enable_i = 4'b1111;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; lookup_valid_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got v=%b b=%b expected v=1 b=1", resp_valid_o, busy_o);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_dest_o !== 32'h0 || pred_dest_o !== 128'h0 || resp_valid_o !== 1'b0 || pred_take_o !== 4'b0) begin
      errors++; $display("FAIL async_reset: got b=%b d=%h pd=%h expected all 0", busy_o, valid_dest_o, pred_dest_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b expected 0", busy_o);
    end
    do_lookup(32'h1000_0040, 4'b1111);
    checks++;
    if (resp_valid_o !== 1'b1 || any_take_o !== 1'b0 || valid_dest_o !== 32'h1000_0050) begin
      errors++; $display("FAIL post_reset_lookup: got v=%b a=%b d=%h expected v=1 a=0 d=10000050", resp_valid_o, any_take_o, valid_dest_o);
    end
  endtask

  initial begin
    test_reset();
    test_miss_lookup();
    test_alloc();
    test_saturation();
    test_enable_mask();
    test_back_to_back();
    test_flush();
    test_flush_restart();
    test_stall();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
